// File: rtl/present_ctrl.sv
// present_ctrl: iterative PRESENT-80 encryption controller, one round per clock.
// Includes the s_box and data_update round datapath it is built around.

module s_box (
    input  logic [3:0] a,
    output logic [3:0] y
);
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
    assign y = SBOX[{a, 2'b00} +: 4];
endmodule

module data_update (
    input  logic [63:0] Data_ib,
    input  logic [63:0] RoundKey_ib,
    output logic [63:0] Data_ob
);
    logic [63:0] x;
    logic [63:0] s;
    assign x = Data_ib ^ RoundKey_ib;
    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_sbox
            s_box u_sbox (.a(x[4*i +: 4]), .y(s[4*i +: 4]));
        end
        // pLayer: bit i moves to bit i*16 mod 63, bit 63 stays put
        for (i = 0; i < 63; i++) begin : g_perm
            assign Data_ob[(i * 16) % 63] = s[i];
        end
    endgenerate
    assign Data_ob[63] = s[63];
endmodule

module present_ctrl (
    input  logic        Clk_ik,
    input  logic        Reset_irn,
    input  logic        Start_i,
    input  logic [63:0] Plaintext_ib,
    input  logic [79:0] Key_ib,
    output logic        Ready_o,
    output logic        Done_o,
    output logic [63:0] Ciphertext_ob
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]  fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  round_q, round_d;
    logic        done_q, done_d;
    logic [63:0] ct_q, ct_d;
    logic [63:0] data_next;
    logic [79:0] k_rot, key_next;
    logic [3:0]  k_sbox;

    data_update u_round (.Data_ib(state_q), .RoundKey_ib(key_q[79:16]), .Data_ob(data_next));

    assign k_rot = {key_q[18:0], key_q[79:19]};
    s_box u_ksbox (.a(k_rot[79:76]), .y(k_sbox));
    assign key_next = {k_sbox, k_rot[75:20], k_rot[19:15] ^ round_q, k_rot[14:0]};

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        ct_d    = ct_q;
        if (fsm_q == IDLE && Start_i) begin
            state_d = Plaintext_ib;
            key_d   = Key_ib;
            round_d = 5'd1;
            fsm_d   = ROUND;
        end else if (fsm_q == ROUND) begin
            state_d = data_next;
            key_d   = key_next;
            round_d = round_q + 5'd1;
            fsm_d   = (round_q == 5'd31) ? FINAL : ROUND;
        end else if (fsm_q == FINAL) begin
            ct_d   = state_q ^ key_q[79:16];
            done_d = 1'b1;
            fsm_d  = IDLE;
        end
    end

    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
        end
    end

    assign Ready_o       = (fsm_q == IDLE);
    assign Done_o        = done_q;
    assign Ciphertext_ob = ct_q;
endmodule

// File: tb/tb_present_ctrl.sv
// tb_present_ctrl: directed-vector bench for present_ctrl using standard PRESENT-80 test vectors.

module tb_present_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] pt = '0;
    logic [79:0] key = '0;
    logic        ready, done;
    logic [63:0] ct;
    logic [63:0] saved;
    int          checks = 0;
    int          failures = 0;
    int          n;

    logic [63:0] vp [3] = '{64'h0, {64{1'b1}}, {64{1'b1}}};
    logic [79:0] vk [3] = '{{80{1'b1}}, 80'h0, {80{1'b1}}};
    logic [63:0] vc [3] = '{64'hE72C46C0F5945049, 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};

    present_ctrl dut (
        .Clk_ik(clk), .Reset_irn(rst_n), .Start_i(start), .Plaintext_ib(pt),
        .Key_ib(key), .Ready_o(ready), .Done_o(done), .Ciphertext_ob(ct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until Done_o, bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(input string tag, input int exp_n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
        chk(tag, 80'(n), 80'(exp_n));
    endtask

    initial begin
        #12;
        chk("rst_ready", 80'(ready), 80'd1);
        chk("rst_done", 80'(done), 80'd0);
        chk("rst_ct", 80'(ct), 80'd0);
        // release with start already high: accept at the first edge after release
        pt = '0; key = '0; start = 1'b1;
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_accept", 80'(ready), 80'd0);
        tick();
        chk("key_after_e1", dut.key_q, 80'hC0000000000000008000);
        wait_done("latency0", 31);
        chk("ct_zero", 80'(ct), 80'h5579C1387B228445);
        chk("ready_at_done", 80'(ready), 80'd1);
        tick();
        chk("done_one_cycle", 80'(done), 80'd0);

        pt = vp[0]; key = vk[0]; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wait_done("b2b_latency", 32);
            chk("b2b_ct", 80'(ct), 80'(vc[i]));
            if (i < 2) begin
                pt = vp[i+1];
                key = vk[i+1];
            end else begin
                start = 1'b0;
            end
            tick();
            chk("b2b_done_drop", 80'(done), 80'd0);
            chk("b2b_ready", 80'(ready), (i < 2) ? 80'd0 : 80'd1);
        end

        pt = '0; key = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("busy_ready", 80'(ready), 80'd0);
            if (k == 4 || k == 30) begin
                start = 1'b1;
                pt = {64{1'b1}};
                key = {80{1'b1}};
            end
            if (k == 5 || k == 31) start = 1'b0;
        end
        tick();
        chk("busy_done", 80'(done), 80'd1);
        chk("busy_ct", 80'(ct), 80'h5579C1387B228445);
        chk("busy_ready_final", 80'(ready), 80'd1);

        tick();
        pt = {64{1'b1}}; key = {80{1'b1}}; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 80'(ready), 80'd1);
        chk("midrst_done", 80'(done), 80'd0);
        chk("midrst_ct", 80'(ct), 80'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("midrst_no_done", 80'(done), 80'd0);
        end
        pt = {64{1'b1}}; key = '0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("post_rst_latency", 32);
        chk("post_rst_ct", 80'(ct), 80'hA112FFC72F68417B);

        saved = 64'hA112FFC72F68417B;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("hold_done", 80'(done), 80'd0);
            chk("hold_ct", 80'(ct), 80'(saved));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
